// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/issue and result/writeback handshakes of seq_alu.
// The master issues operations and consumes results; the ALU is the slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [5:0]       opCode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, operand1, operand2, opCode, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, operand1, operand2, opCode, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle logic/arith/shift ops and
// bit-serial multiply and unsigned divide/remainder.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_AND  = 6'h02;
    localparam logic [5:0] OP_OR   = 6'h03;
    localparam logic [5:0] OP_SLT  = 6'h04;
    localparam logic [5:0] OP_SLTU = 6'h05;
    localparam logic [5:0] OP_XOR  = 6'h06;
    localparam logic [5:0] OP_NOR  = 6'h07;
    localparam logic [5:0] OP_SLL  = 6'h08;
    localparam logic [5:0] OP_SRL  = 6'h09;
    localparam logic [5:0] OP_SRA  = 6'h0A;
    localparam logic [5:0] OP_MUL  = 6'h0B;
    localparam logic [5:0] OP_DIVU = 6'h0C;
    localparam logic [5:0] OP_REMU = 6'h0D;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [5:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    // MUL: lo = multiplier, hi = partial product, mc = shifted multiplicand
    // DIVU/REMU: lo = dividend -> quotient, hi = remainder, mc = divisor
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] mc_q;
    logic [SW-1:0]    cnt;

    logic             is_long;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;
    logic             ill_d;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic [SW-1:0]    shamt;

    // Classify the offered op: divide by zero takes the short path.
    always_comb begin
        is_long = 1'b0;
        if (bus.opCode == OP_MUL) begin
            is_long = 1'b1;
        end else if (bus.opCode == OP_DIVU || bus.opCode == OP_REMU) begin
            is_long = (bus.operand2 != '0);
        end
    end

    // One restoring-division step: shift in next dividend bit, try subtract.
    always_comb begin
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, mc_q};
    end

    // Final result and flags from the latched operands / iteration registers.
    always_comb begin
        sum   = a_q + b_q;
        dif   = a_q - b_q;
        shamt = b_q[SW-1:0];
        res_d = '0;
        ovf_d = 1'b0;
        ill_d = 1'b0;
        unique case (op_q)
            OP_ADD: begin
                res_d = sum;
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1])
                     && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = dif;
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1])
                     && (dif[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_AND:  res_d = a_q & b_q;
            OP_OR:   res_d = a_q | b_q;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, a_q < b_q};
            OP_XOR:  res_d = a_q ^ b_q;
            OP_NOR:  res_d = ~(a_q | b_q);
            OP_SLL:  res_d = a_q << shamt;
            OP_SRL:  res_d = a_q >> shamt;
            OP_SRA:  res_d = $signed(a_q) >>> shamt;
            OP_MUL:  res_d = hi_q;
            OP_DIVU: res_d = (b_q == '0) ? '1 : lo_q;
            OP_REMU: res_d = (b_q == '0) ? a_q : hi_q;
            default: ill_d = 1'b1;
        endcase
    end

    // Control FSM, operand capture, serial iteration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            mc_q          <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q         <= bus.opCode;
                        a_q          <= bus.operand1;
                        b_q          <= bus.operand2;
                        hi_q         <= '0;
                        cnt          <= '1;
                        bus.in_ready <= 1'b0;
                        if (bus.opCode == OP_MUL) begin
                            lo_q <= bus.operand2;
                            mc_q <= bus.operand1;
                        end else begin
                            lo_q <= bus.operand1;
                            mc_q <= bus.operand2;
                        end
                        state <= is_long ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    if (op_q == OP_MUL) begin
                        if (lo_q[0]) begin
                            hi_q <= hi_q + mc_q;
                        end
                        mc_q <= mc_q << 1;
                        lo_q <= lo_q >> 1;
                    end else if (!div_diff[WIDTH]) begin
                        hi_q <= div_diff[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_q <= div_sh[WIDTH-1:0];
                        lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.out_valid) begin
                        bus.out_valid <= 1'b1;
                        bus.result    <= res_d;
                        bus.zero      <= (res_d == '0);
                        bus.overflow  <= ovf_d;
                        bus.illegal   <= ill_d;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
